// File: rtl/trim_pwm_capture_pkg.sv
// trim_pwm_pkg: shared FSM states, counter width and saturation limit for the TrimPWM capture block
package trim_pwm_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int RESOLUTION = 8;
  localparam int CNT_W = RESOLUTION + 1;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/trim_pwm_sync_edge.sv
// trim_pwm_sync_edge: pwm_in synchronizer and edge detector, 3-sample filter when TRIM_PWM_CAPTURE_GLITCH_FILTER_EN is defined
module trim_pwm_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s, s_d;
  always_ff @(posedge clock or posedge reset)
    if (reset) {s1, s, s_d} <= '0;
    else {s1, s, s_d} <= {pwm_in, s1, s};
`ifdef TRIM_PWM_CAPTURE_GLITCH_FILTER_EN
  logic s_dd, f, f_nxt;
  // rise/fall are taken from the next filtered level so the filter adds only two clocks
  always_comb f_nxt = (s & s_d & s_dd) ? 1'b1 : (~s & ~s_d & ~s_dd) ? 1'b0 : f;
  always_ff @(posedge clock or posedge reset)
    if (reset) {s_dd, f} <= '0;
    else {s_dd, f} <= {s_d, f_nxt};
  assign level = f;
  assign rise = f_nxt & ~f;
  assign fall = ~f_nxt & f;
`else
  assign level = s;
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
`endif
endmodule

// File: rtl/trim_pwm_capture.sv
// trim_pwm_capture: PWM high-time/period decoder with valid/ack result handshake (filter: TRIM_PWM_CAPTURE_GLITCH_FILTER_EN)
module trim_pwm_capture import trim_pwm_pkg::*; #(
  parameter int Resolution = CNT_W - 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                pwm_in,
  input  logic                ack,
  output logic                valid,
  output logic [Resolution:0] high_time,
  output logic [Resolution:0] period,
  output logic                ovf,
  output logic                lost
);
  localparam int CW = Resolution + 1;
  localparam logic [CW-1:0] MAX = CW'(cnt_max(CW));
  state_t state;
  logic [CW-1:0] cnt, hi_lat, cnt_inc, pub_hi, pub_per;
  logic level, rise, fall, sat, closed, pub;
  trim_pwm_sync_edge u_sync (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
    .level(level), .rise(rise), .fall(fall)
  );
  // a timeout still in the high phase has no falling edge, so its high time is MAX
  always_comb begin
    sat = cnt == MAX;
    cnt_inc = sat ? MAX : cnt + 1'b1;
    closed = state == LOW && rise;
    pub = en && (closed || (state != IDLE && sat && !rise && !fall));
    pub_hi = (!closed && level) ? MAX : hi_lat;
    pub_per = closed ? cnt : MAX;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi_lat <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin state <= HIGH; cnt <= CW'(1); end
        HIGH: if (fall) begin state <= LOW; hi_lat <= cnt; cnt <= cnt_inc; end
              else if (sat) begin state <= IDLE; cnt <= '0; end
              else cnt <= cnt_inc;
        LOW:  if (rise) begin state <= HIGH; cnt <= CW'(1); end
              else if (sat) begin state <= IDLE; cnt <= '0; end
              else cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
  // an ack landing with a publish keeps valid set and leaves lost alone
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      lost <= 1'b0;
      ovf <= 1'b0;
      high_time <= '0;
      period <= '0;
    end else begin
      valid <= pub | (valid & ~ack);
      lost <= pub ? (lost | (valid & ~ack)) : (lost & ~(valid & ack));
      if (pub) begin
        high_time <= pub_hi;
        period <= pub_per;
        ovf <= ~closed;
      end
    end
endmodule

// File: tb/tb_trim_pwm_capture.sv
// tb_trim_pwm_capture: randomized and directed checks of trim_pwm_capture against a timestamp-based reference model
module tb_trim_pwm_capture;
  localparam int R = 8;
  localparam int W = R + 1;
  localparam int MAX = (1 << W) - 1;
`ifdef TRIM_PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  logic clock = 0, reset = 0, en = 1, pwm_in = 0, ack = 0;
  logic valid, ovf, lost;
  logic [W-1:0] high_time, period;
  typedef struct {int h; int p; bit o;} res_t;
  res_t exp_q[$];
  int n_chk = 0, n_pass = 0, pc = 0, n_res = 0;
  int first_h, first_p, last_h, last_p;
  bit first_o, last_o, got_first, saw_h1;
  int mn, mt0, mtf;
  bit marmed, mfell, mlvl;
  bit [2:0] mhist;

  trim_pwm_capture #(.Resolution(R)) dut (
    .clock(clock), .reset(reset), .en(en), .pwm_in(pwm_in), .ack(ack),
    .valid(valid), .high_time(high_time), .period(period), .ovf(ovf), .lost(lost)
  );

  always #5 clock = ~clock;

  // reference: timestamps of sampled edges; a result is the gap between rises, or a timeout after MAX cycles
  task automatic model_step();
    bit nl, r, f;
    int d;
    if (reset) begin
      marmed = 0; mlvl = 0; mhist = 0; mn = 0;
      return;
    end
    mn++;
    mhist = {mhist[1:0], pwm_in};
`ifdef TRIM_PWM_CAPTURE_GLITCH_FILTER_EN
    nl = (mhist == 3'b111) ? 1'b1 : (mhist == 3'b000) ? 1'b0 : mlvl;
`else
    nl = pwm_in;
`endif
    r = nl & ~mlvl;
    f = ~nl & mlvl;
    mlvl = nl;
    if (!en) marmed = 0;
    else if (marmed) begin
      d = mn - mt0;
      if (r) begin
        exp_q.push_back('{mtf - mt0, (d > MAX) ? MAX : d, 1'b0});
        mt0 = mn; mfell = 0;
      end else if (f) begin
        mfell = 1; mtf = mn;
      end else if (d >= MAX) begin
        exp_q.push_back('{mfell ? mtf - mt0 : MAX, MAX, 1'b1});
        marmed = 0;
      end
    end else if (r) begin
      marmed = 1; mt0 = mn; mfell = 0;
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  // TrimPWM-style source: high while pc < cmp, optional one-clock pulse at pc == glitch
  task automatic run(input int n, input int cmp, input bit auto_ack, input int glitch, input int ack_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (auto_ack) begin
        if (valid) begin
          n_chk++;
          if (exp_q.size() == 0)
            $display("FAIL unexpected_result: got high=%0d period=%0d ovf=%0b, model has none", high_time, period, ovf);
          else begin
            res_t e;
            e = exp_q.pop_front();
            if (high_time !== W'(e.h) || period !== W'(e.p) || ovf !== e.o)
              $display("FAIL model_result: got high=%0d period=%0d ovf=%0b, want high=%0d period=%0d ovf=%0b",
                       high_time, period, ovf, e.h, e.p, e.o);
            else n_pass++;
          end
          if (!got_first) begin
            got_first = 1; first_h = int'(high_time); first_p = int'(period); first_o = ovf;
          end
          last_h = int'(high_time); last_p = int'(period); last_o = ovf;
          if (high_time == W'(1)) saw_h1 = 1;
          n_res++;
          ack = 1;
        end else ack = 0;
      end else ack = (i == ack_at);
      pwm_in = (pc < cmp) || (pc == glitch);
      pc = (pc + 1) % 256;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; en = 1; ack = 0; pwm_in = 0; pc = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    exp_q.delete();
    got_first = 0; saw_h1 = 0; n_res = 0;
  endtask

  task automatic test_reset();
    reset = 1; en = 1; ack = 0; pwm_in = 0;
    repeat (3) @(negedge clock);
    n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
    n_chk++; if (lost !== 1'b0) $display("FAIL reset_lost: got %0b want 0", lost); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf); else n_pass++;
    n_chk++; if (high_time !== '0) $display("FAIL reset_high: got %0d want 0", high_time); else n_pass++;
    n_chk++; if (period !== '0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
    reset = 0; pc = 0;
    exp_q.delete();
  endtask

  task automatic test_trim64_then_stuck_low();
    int n0;
    do_reset();
    run(256 * 6, 64, 1, -1, -1);
    n_chk++; if (n_res !== 5) $display("FAIL trim64_count: got %0d want 5", n_res); else n_pass++;
    n_chk++; if (last_h !== 64 || last_p !== 256 || last_o !== 1'b0)
      $display("FAIL trim64_value: got %0d/%0d ovf=%0b want 64/256 ovf=0", last_h, last_p, last_o); else n_pass++;
    n_chk++; if (lost !== 1'b0 || valid !== 1'b0)
      $display("FAIL trim64_flags: got lost=%0b valid=%0b want 0/0", lost, valid); else n_pass++;
    n0 = n_res;
    run(256 * 5, 0, 1, -1, -1);
    n_chk++; if (n_res - n0 !== 1) $display("FAIL stuck_low_count: got %0d want 1", n_res - n0); else n_pass++;
    n_chk++; if (last_h !== 64 || last_p !== MAX || last_o !== 1'b1)
      $display("FAIL stuck_low_value: got %0d/%0d ovf=%0b want 64/%0d ovf=1", last_h, last_p, last_o, MAX); else n_pass++;
    n_chk++; if (exp_q.size() !== 0) $display("FAIL stuck_low_pending: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_no_ack();
    do_reset();
    run(256 * 4, 128, 0, -1, -1);
    n_chk++; if (valid !== 1'b1 || lost !== 1'b1)
      $display("FAIL no_ack_flags: got valid=%0b lost=%0b want 1/1", valid, lost); else n_pass++;
    n_chk++; if (high_time !== W'(128) || period !== W'(256) || ovf !== 1'b0)
      $display("FAIL no_ack_value: got %0d/%0d ovf=%0b want 128/256 ovf=0", high_time, period, ovf); else n_pass++;
    run(2, 128, 0, -1, 0);
    n_chk++; if (valid !== 1'b0 || lost !== 1'b0)
      $display("FAIL no_ack_clear: got valid=%0b lost=%0b want 0/0", valid, lost); else n_pass++;
  endtask

  task automatic test_ack_with_publish();
    do_reset();
    run(256, 128, 0, -1, -1);
    run(256, 100, 0, -1, -1);
    run(LAT, 100, 0, -1, LAT - 1);
    n_chk++; if (valid !== 1'b1 || high_time !== W'(128))
      $display("FAIL latency_before: got valid=%0b high=%0d want 1/128", valid, high_time); else n_pass++;
    run(1, 100, 0, -1, -1);
    n_chk++; if (valid !== 1'b1 || lost !== 1'b0)
      $display("FAIL ack_publish_flags: got valid=%0b lost=%0b want 1/0", valid, lost); else n_pass++;
    n_chk++; if (high_time !== W'(100) || period !== W'(256))
      $display("FAIL ack_publish_value: got %0d/%0d want 100/256", high_time, period); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    run(256, 128, 1, -1, -1);
    run(256 * 3, 128, 1, 200, -1);
`ifdef TRIM_PWM_CAPTURE_GLITCH_FILTER_EN
    n_chk++; if (saw_h1 !== 1'b0) $display("FAIL glitch_filtered: got high=1 result, want none"); else n_pass++;
    n_chk++; if (last_h !== 128 || last_p !== 256)
      $display("FAIL glitch_period: got %0d/%0d want 128/256", last_h, last_p); else n_pass++;
`else
    n_chk++; if (saw_h1 !== 1'b1) $display("FAIL glitch_measured: got no high=1 result, want one"); else n_pass++;
`endif
  endtask

  task automatic test_enable_and_reset();
    do_reset();
    run(256, 128, 1, -1, -1);
    run(20, 128, 1, -1, -1);
    en = 0;
    run(10, 128, 1, -1, -1);
    en = 1; got_first = 0;
    run(512, 128, 1, -1, -1);
    n_chk++; if (got_first !== 1'b1 || first_h !== 128 || first_p !== 256 || first_o !== 1'b0)
      $display("FAIL enable_resume: got seen=%0b %0d/%0d ovf=%0b want 1 128/256 ovf=0", got_first, first_h, first_p, first_o); else n_pass++;
    run(256 * 2 + 130, 128, 0, -1, -1);
    n_chk++; if (valid !== 1'b1 || lost !== 1'b1)
      $display("FAIL pre_reset_flags: got valid=%0b lost=%0b want 1/1", valid, lost); else n_pass++;
    #2 reset = 1;
    #1;
    n_chk++; if (valid !== 1'b0 || lost !== 1'b0 || high_time !== '0)
      $display("FAIL async_reset: got valid=%0b lost=%0b high=%0d want 0/0/0", valid, lost, high_time); else n_pass++;
    @(negedge clock);
    reset = 0;
    exp_q.delete(); got_first = 0;
    run(600, 128, 1, -1, -1);
    n_chk++; if (got_first !== 1'b1 || first_h !== 128 || first_p !== 256)
      $display("FAIL reset_resume: got seen=%0b %0d/%0d want 1 128/256", got_first, first_h, first_p); else n_pass++;
  endtask

  task automatic test_random();
    int cmp, k, glitch;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 5);
      cmp = (k == 0) ? 0 : (k == 1) ? 256 : $urandom_range(3, 252);
      glitch = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : -1;
      run(256, cmp, 1, glitch, -1);
    end
    run(256 * 3, 128, 1, -1, -1);
    n_chk++; if (n_res < 3) $display("FAIL random_count: got %0d want >=3", n_res); else n_pass++;
    n_chk++; if (exp_q.size() !== 0) $display("FAIL random_pending: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_trim64_then_stuck_low();
    test_no_ack();
    test_ack_with_publish();
    test_glitch();
    test_enable_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
